// File: rtl/ofm_stream_pkg.sv
// ofm_stream_pkg: sizing helpers, default geometry and FSM encoding
// shared by the OFM stream reader and its word packer.
package ofm_stream_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_INOUT_W   = 128;
   localparam int DEF_OFM_SIZE  = 26;
   localparam int DEF_NO_FILTER = 256;

   localparam int WORD_W = 2 * DEF_DATA_W;
   localparam int WPB    = DEF_INOUT_W / WORD_W;
   localparam int TOTAL  = DEF_OFM_SIZE * DEF_OFM_SIZE * DEF_NO_FILTER;
   localparam int ADDR_W = $clog2(TOTAL);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      FLUSH,
      DRAIN
   } state_e;

   function automatic int f_wpb(input int inout_w, input int data_w);
      return inout_w / (2 * data_w);
   endfunction

   function automatic int f_total(input int ofm_size, input int no_filter);
      return ofm_size * ofm_size * no_filter;
   endfunction

   function automatic int f_addr_w(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/ofm_word_packer.sv
// ofm_word_packer: gathers returned OFM words into one beat; the word
// arriving this cycle is merged into the beat so a full beat can leave at once.
module ofm_word_packer
   import ofm_stream_pkg::*;
#(
   parameter int NW = WPB,
   parameter int WW = WORD_W,
   parameter int KW = $clog2(NW + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             wr,
   input  logic [WW-1:0]    wr_data,
   output logic [NW*WW-1:0] beat,
   output logic [NW-1:0]    keep,
   output logic [KW-1:0]    fill
);

   logic [WW-1:0] buf_q [NW];
   logic [WW-1:0] buf_d [NW];
   logic [KW-1:0] cnt_q;
   logic [KW-1:0] cnt_d;

   always_comb begin
      fill = cnt_q + KW'(wr);
      beat = '0;
      keep = '0;
      for (int k = 0; k < NW; k++) begin
         keep[k] = (KW'(k) < fill);
         beat[k*WW +: WW] = buf_q[k];
         if (wr && (cnt_q == KW'(k))) begin
            beat[k*WW +: WW] = wr_data;
         end
      end
   end

   // clear always consumes the arriving word, since it is already in the beat
   always_comb begin
      buf_d = buf_q;
      cnt_d = fill;
      for (int k = 0; k < NW; k++) begin
         if (wr && (cnt_q == KW'(k))) begin
            buf_d[k] = wr_data;
         end
      end
      if (clear) begin
         cnt_d = '0;
         for (int k = 0; k < NW; k++) begin
            buf_d[k] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         for (int k = 0; k < NW; k++) begin
            buf_q[k] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         for (int k = 0; k < NW; k++) begin
            buf_q[k] <= buf_d[k];
         end
      end
   end

endmodule

// File: rtl/ofm_stream_reader.sv
// ofm_stream_reader: drains the OFM DPRAM into packed valid/ready beats.
// OFM_STREAM_CHECKSUM_EN adds a running sign-extended word checksum.
module ofm_stream_reader
   import ofm_stream_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_W,
   parameter int INOUT_WIDTH = DEF_INOUT_W,
   parameter int OFM_SIZE    = DEF_OFM_SIZE,
   parameter int NO_FILTER   = DEF_NO_FILTER
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_rd_en,
   output logic [f_addr_w(f_total(OFM_SIZE, NO_FILTER))-1:0] mem_rd_addr,
   input  logic [2*DATA_WIDTH-1:0] mem_rd_data,
   output logic [INOUT_WIDTH-1:0] m_data,
   output logic [f_wpb(INOUT_WIDTH, DATA_WIDTH)-1:0] m_keep,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   m_last,
   output logic [31:0]            checksum
);

   localparam int WW   = 2 * DATA_WIDTH;
   localparam int NW   = f_wpb(INOUT_WIDTH, DATA_WIDTH);
   localparam int NTOT = f_total(OFM_SIZE, NO_FILTER);
   localparam int AW   = f_addr_w(NTOT);
   localparam int CW   = $clog2(NTOT + 1);
   localparam int KW   = $clog2(NW + 1);
   localparam logic [CW-1:0] LAST_A = CW'(NTOT - 1);
   localparam logic [CW-1:0] END_A  = CW'(NTOT);
   localparam logic [KW-1:0] FULL   = KW'(NW);

   state_e                 state_q, state_d;
   logic [CW-1:0]          addr_q, addr_d;
   logic                   inflight_q, inflight_d;
   logic                   done_q, done_d;
   logic                   obuf_valid_q, obuf_valid_d;
   logic [INOUT_WIDTH-1:0] obuf_data_q, obuf_data_d;
   logic [NW-1:0]          obuf_keep_q, obuf_keep_d;
   logic                   obuf_last_q, obuf_last_d;

   logic                   out_free, hs, accept, xfer, rd_en;
   logic [INOUT_WIDTH-1:0] pk_beat;
   logic [NW-1:0]          pk_keep;
   logic [KW-1:0]          pk_fill;

   ofm_word_packer #(
      .NW(NW),
      .WW(WW),
      .KW(KW)
   ) u_packer (
      .clk    (clk),
      .rst    (rst),
      .clear  (xfer),
      .wr     (inflight_q),
      .wr_data(mem_rd_data),
      .beat   (pk_beat),
      .keep   (pk_keep),
      .fill   (pk_fill)
   );

   // a read may issue into a slot freed by a beat leaving this same cycle
   always_comb begin
      out_free = !obuf_valid_q || m_ready;
      hs       = obuf_valid_q && m_ready;
      accept   = (state_q == IDLE) && start && !done_q;
      xfer     = out_free
               && (((state_q == READ) && (pk_fill == FULL))
               ||  ((state_q == FLUSH) && (pk_fill != '0)));
      rd_en    = (state_q == READ) && (addr_q < END_A)
               && (xfer || (pk_fill < FULL));
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      inflight_d   = rd_en;
      done_d       = 1'b0;
      obuf_valid_d = obuf_valid_q;
      obuf_data_d  = obuf_data_q;
      obuf_keep_d  = obuf_keep_q;
      obuf_last_d  = obuf_last_q;
      if (hs) begin
         obuf_valid_d = 1'b0;
         obuf_data_d  = '0;
         obuf_keep_d  = '0;
         obuf_last_d  = 1'b0;
      end
      if (xfer) begin
         obuf_valid_d = 1'b1;
         obuf_data_d  = pk_beat;
         obuf_keep_d  = pk_keep;
         obuf_last_d  = (state_q == FLUSH);
      end
      if (rd_en) begin
         addr_d = addr_q + CW'(1);
      end
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = READ;
               addr_d  = '0;
            end
         end
         READ: begin
            if (rd_en && (addr_q == LAST_A)) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (xfer) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (hs) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         inflight_q   <= 1'b0;
         done_q       <= 1'b0;
         obuf_valid_q <= 1'b0;
         obuf_data_q  <= '0;
         obuf_keep_q  <= '0;
         obuf_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         inflight_q   <= inflight_d;
         done_q       <= done_d;
         obuf_valid_q <= obuf_valid_d;
         obuf_data_q  <= obuf_data_d;
         obuf_keep_q  <= obuf_keep_d;
         obuf_last_q  <= obuf_last_d;
      end
   end

`ifdef OFM_STREAM_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (accept) begin
         csum_d = '0;
      end else if (inflight_q) begin
         csum_d = csum_q + {{(32-WW){mem_rd_data[WW-1]}}, mem_rd_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign mem_rd_en   = rd_en;
   assign mem_rd_addr = addr_q[AW-1:0];
   assign m_data      = obuf_data_q;
   assign m_keep      = obuf_keep_q;
   assign m_valid     = obuf_valid_q;
   assign m_last      = obuf_last_q;

endmodule
